alu_ctrl_seq: RTL and testbench

- Control sequencer for the 64-bit ALU datapath.
- Generates the c0..c10 strobes that drive the A accumulator, Q register, M register, adder and outbus drivers.
- Runs radix-2 Booth signed multiplication and non-restoring unsigned division.
- Sits directly upstream of the A/Q/M registers and consumes their status bits.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_ctrl_seq_if.sv | 30 +++
 rtl/alu_iter_cnt.sv | 33 +++
 rtl/alu_ctrl_seq.sv | 109 ++++++++++
 tb/tb_alu_ctrl_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU control sequencer: state encoding, op codes,
// strobe bit positions and the per-state Moore strobe decode.
package alu_pkg;

  typedef enum logic [3:0] {
    IDLE, LOAD_Q, LOAD_M, MUL_ADD, MUL_SHIFT, DIV_SHIFT,
    DIV_ADD, DIV_QBIT, DIV_CORR, OUT_A, OUT_Q, DONE
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int C0    = 0;
  localparam int C1    = 1;
  localparam int C2    = 2;
  localparam int C3    = 3;
  localparam int C4    = 4;
  localparam int C5    = 5;
  localparam int C6    = 6;
  localparam int C7    = 7;
  localparam int C8    = 8;
  localparam int C9    = 9;
  localparam int C10   = 10;
  localparam int NSTRB = 11;

  // State-only strobes; the q0/q_m1/a_msb qualified terms are added at the top level.
  function automatic logic [NSTRB-1:0] moore_strb(input state_e s);
    logic [NSTRB-1:0] v;
    v = '0;
    case (s)
      LOAD_Q:    v[C0] = 1'b1;
      LOAD_M:    begin v[C1] = 1'b1; v[C7] = 1'b1; end
      MUL_SHIFT: begin v[C10] = 1'b1; v[C9] = 1'b1; end
      DIV_SHIFT: v[C8] = 1'b1;
      DIV_ADD:   v[C2] = 1'b1;
      DIV_QBIT:  begin v[C4] = 1'b1; v[C9] = 1'b1; end
      DIV_CORR:  v[C2] = 1'b1;
      OUT_A:     v[C5] = 1'b1;
      OUT_Q:     v[C6] = 1'b1;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Handshake, datapath status and strobe bundle between the ALU datapath
// (master side) and the control sequencer (slave side).
interface alu_ctrl_seq_if #(
  parameter int W  = 64,
  parameter int CW = $clog2(W) + 1
);
  logic          start;
  logic          op;
  logic          q0;
  logic          q_m1;
  logic          a_msb;
  logic          m_zero;
  logic          c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          done;
  logic          div0_err;

  modport master (
    output start, op, q0, q_m1, a_msb, m_zero,
    input  c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10,
    input  cnt, busy, done, div0_err
  );

  modport slave (
    input  start, op, q0, q_m1, a_msb, m_zero,
    output c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10,
    output cnt, busy, done, div0_err
  );
endinterface

// File: rtl/alu_iter_cnt.sv
// Iteration counter for the sequencer: synchronous clear, saturating
// increment and a last-iteration flag (count == W-1 before increment).
module alu_iter_cnt #(
  parameter int W  = 64,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && cnt_q != CW'(W))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(W - 1));
endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: Booth multiply / non-restoring divide strobe FSM.
// Optional ALU_CTRL_DIV0_DETECT_EN short-circuits divide-by-zero to DONE.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int W  = 64,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_ctrl_seq_if.slave bus
);
  state_e           state_q, state_d;
  logic             op_q;
  logic [NSTRB-1:0] strb_q;
  logic             busy_q;
  logic             done_q;
  logic             last;
  logic [CW-1:0]    cnt_w;
  logic             mul_add, div_add;

  alu_iter_cnt #(.W(W), .CW(CW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == LOAD_Q),
    .inc_i  (state_q == MUL_SHIFT || state_q == DIV_QBIT),
    .cnt_o  (cnt_w),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.start) state_d = LOAD_Q;
      LOAD_Q:    state_d = LOAD_M;
`ifdef ALU_CTRL_DIV0_DETECT_EN
      LOAD_M:    if (op_q == OP_DIV && bus.m_zero) state_d = DONE;
                 else state_d = (op_q == OP_MUL) ? MUL_ADD : DIV_SHIFT;
`else
      LOAD_M:    state_d = (op_q == OP_MUL) ? MUL_ADD : DIV_SHIFT;
`endif
      MUL_ADD:   state_d = MUL_SHIFT;
      MUL_SHIFT: state_d = last ? OUT_A : MUL_ADD;
      DIV_SHIFT: state_d = DIV_ADD;
      DIV_ADD:   state_d = DIV_QBIT;
      DIV_QBIT:  if (last) state_d = bus.a_msb ? DIV_CORR : OUT_Q;
                 else state_d = DIV_SHIFT;
      DIV_CORR:  state_d = OUT_Q;
      OUT_A:     state_d = (op_q == OP_MUL) ? OUT_Q : DONE;
      OUT_Q:     state_d = (op_q == OP_MUL) ? DONE : OUT_A;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Moore strobes, busy and done are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      strb_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      strb_q  <= moore_strb(state_d);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (state_q == IDLE && bus.start)
        op_q <= bus.op;
    end
  end

`ifdef ALU_CTRL_DIV0_DETECT_EN
  logic div0_q;
  always_ff @(posedge clk) begin
    if (rst)
      div0_q <= 1'b0;
    else if (state_d == LOAD_Q)
      div0_q <= 1'b0;
    else if (state_q == LOAD_M && op_q == OP_DIV && bus.m_zero)
      div0_q <= 1'b1;
  end
  assign bus.div0_err = div0_q;
`else
  logic unused_m_zero;
  assign unused_m_zero = bus.m_zero;
  assign bus.div0_err  = 1'b0;
`endif

  assign mul_add = (state_q == MUL_ADD);
  assign div_add = (state_q == DIV_ADD);

  assign bus.c0   = strb_q[C0];
  assign bus.c1   = strb_q[C1];
  assign bus.c2   = strb_q[C2] | (mul_add & (bus.q0 ^ bus.q_m1));
  // Booth 10 subtracts; divide subtracts M while A is non-negative.
  assign bus.c3   = strb_q[C3] | (mul_add & bus.q0 & ~bus.q_m1) | (div_add & ~bus.a_msb);
  assign bus.c4   = strb_q[C4];
  assign bus.c5   = strb_q[C5];
  assign bus.c6   = strb_q[C6];
  assign bus.c7   = strb_q[C7];
  assign bus.c8   = strb_q[C8];
  assign bus.c9   = strb_q[C9];
  assign bus.c10  = strb_q[C10];
  assign bus.cnt  = cnt_w;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: W=4 instance for sequence detail,
// W=64 instance for the full-width multiply.
module tb_alu_ctrl_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.W(4))  b4 ();
  alu_ctrl_seq_if #(.W(64)) b64 ();

  alu_ctrl_seq #(.W(4))  u_dut4  (.clk(clk), .rst(rst), .bus(b4));
  alu_ctrl_seq #(.W(64)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

  int n_chk = 0;
  int n_err = 0;

  wire [10:0] st4 = {b4.c10, b4.c9, b4.c8, b4.c7, b4.c6, b4.c5,
                     b4.c4, b4.c3, b4.c2, b4.c1, b4.c0};

  logic [10:0] tr_s [0:31];
  int done_cyc, done_cnt, viol, cnt_done, err_done;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_bit(input int b);
    int n;
    n = 0;
    for (int c = 1; c < 32; c++) if (tr_s[c][b]) n++;
    return n;
  endfunction

  // mvec: four {q0,q_m1} pairs, first iteration in the MSBs.
  // apat: a_msb per divide iteration, first iteration in the MSB.
  task automatic run4(input logic op_v, input logic [7:0] mvec, input logic [3:0] apat,
                      input logic m0, input int glitch);
    b4.start = 1'b1; b4.op = op_v; b4.m_zero = m0;
    b4.q0 = 1'b0; b4.q_m1 = 1'b0; b4.a_msb = 1'b0;
    step;
    b4.start = 1'b0;
    b4.op    = ~op_v;
    done_cyc = 0; done_cnt = 0; viol = 0; cnt_done = -1; err_done = -1;
    for (int cyc = 1; cyc < 32; cyc++) begin
      int idx;
      b4.start = (cyc == glitch);
      idx = (cyc >= 3) ? (cyc - 3) / 2 : 0;
      if (idx > 3) idx = 3;
      {b4.q0, b4.q_m1} = mvec[7 - 2*idx -: 2];
      idx = (cyc >= 3) ? (cyc - 3) / 3 : 0;
      if (idx > 3) idx = 3;
      b4.a_msb = apat[3 - idx];
      #1;
      tr_s[cyc] = st4;
      if (b4.done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          cnt_done = int'(b4.cnt);
          err_done = int'(b4.div0_err);
        end
      end
      if ((st4[2] && (st4[10] || st4[8])) || (st4[5] && st4[6])) viol++;
      step;
    end
    b4.start = 1'b0;
  endtask

  initial begin
    int c10n, d64, cnt64;
    bit seen;
    rst = 1'b1;
    b4.start = 0; b4.op = 0; b4.q0 = 0; b4.q_m1 = 0; b4.a_msb = 0; b4.m_zero = 0;
    b64.start = 0; b64.op = 0; b64.q0 = 0; b64.q_m1 = 0; b64.a_msb = 0; b64.m_zero = 0;
    step; step;
    chk("rst_strobes", st4, 0);
    chk("rst_busy", b4.busy, 0);
    chk("rst_cnt", b4.cnt, 0);
    chk("rst_done", b4.done, 0);
    chk("rst_div0", b4.div0_err, 0);
    rst = 1'b0;
    step;

    // Reset in the middle of a multiply (cycle 4 = first MUL_SHIFT)
    b4.start = 1'b1; b4.op = 1'b0;
    step;
    b4.start = 1'b0;
    step; step; step;
    chk("mid_in_mul_shift", st4, 11'h600);
    rst = 1'b1;
    step;
    chk("mid_rst_strobes", st4, 0);
    chk("mid_rst_busy", b4.busy, 0);
    chk("mid_rst_cnt", b4.cnt, 0);
    chk("mid_rst_done", b4.done, 0);
    rst = 1'b0;
    step;
    chk("post_rst_done", b4.done, 0);
    chk("post_rst_busy", b4.busy, 0);

    // Multiply, Booth pairs 10,11,01,00, stray start at cycle 5
    run4(1'b0, 8'b10_11_01_00, 4'b0000, 1'b0, 5);
    chk("mul_load_q", tr_s[1], 11'h001);
    chk("mul_load_m", tr_s[2], 11'h082);
    chk("mul_add0_c2c3", {tr_s[3][2], tr_s[3][3]}, 2'b11);
    chk("mul_shift0", tr_s[4], 11'h600);
    chk("mul_add1_c2", tr_s[5][2], 0);
    chk("mul_add2_c2c3", {tr_s[7][2], tr_s[7][3]}, 2'b10);
    chk("mul_add3_c2", tr_s[9][2], 0);
    chk("mul_c10_pulses", cnt_bit(10), 4);
    chk("mul_out_a", tr_s[11], 11'h020);
    chk("mul_out_q", tr_s[12], 11'h040);
    chk("mul_done_cyc", done_cyc, 13);
    chk("mul_done_count", done_cnt, 1);
    chk("mul_cnt_end", cnt_done, 4);
    chk("mul_excl", viol, 0);

    // Divide, final a_msb=1 -> remainder correction
    run4(1'b1, 8'h00, 4'b0101, 1'b0, 0);
    chk("div_add0", {tr_s[4][2], tr_s[4][3]}, 2'b11);
    chk("div_add1", {tr_s[7][2], tr_s[7][3]}, 2'b10);
    chk("div_qbit3", tr_s[14], 11'h210);
    chk("div_c8_pulses", cnt_bit(8), 4);
    chk("div_corr", tr_s[15], 11'h004);
    chk("div_out_q", tr_s[16], 11'h040);
    chk("div_out_a", tr_s[17], 11'h020);
    chk("div_corr_done_cyc", done_cyc, 18);
    chk("div_done_count", done_cnt, 1);
    chk("div_cnt_end", cnt_done, 4);
    chk("div_err", err_done, 0);
    chk("div_excl", viol, 0);

    // Divide, final a_msb=0 -> no correction
    run4(1'b1, 8'h00, 4'b1010, 1'b0, 0);
    chk("div2_add0_c3", tr_s[4][3], 0);
    chk("div2_add1_c3", tr_s[7][3], 1);
    chk("div2_out_q", tr_s[15], 11'h040);
    chk("div2_out_a", tr_s[16], 11'h020);
    chk("div2_done_cyc", done_cyc, 17);
    chk("div2_excl", viol, 0);

    // Divide by zero
    run4(1'b1, 8'h00, 4'b0101, 1'b1, 0);
`ifdef ALU_CTRL_DIV0_DETECT_EN
    chk("div0_done_cyc", done_cyc, 3);
    chk("div0_err", err_done, 1);
    chk("div0_no_c2", cnt_bit(2), 0);
    chk("div0_no_c5", cnt_bit(5), 0);
    chk("div0_no_c6", cnt_bit(6), 0);
    chk("div0_err_held", b4.div0_err, 1);
`else
    chk("div0_done_cyc", done_cyc, 18);
    chk("div0_err", err_done, 0);
    chk("div0_c8_pulses", cnt_bit(8), 4);
`endif

    // Full-width multiply on the W=64 instance
    b64.start = 1'b1; b64.op = 1'b0;
    step;
    b64.start = 1'b0;
    c10n = 0; d64 = 0; cnt64 = -1; seen = 0;
    for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
      if (b64.c10) c10n++;
      if (b64.done) begin
        seen  = 1;
        d64   = cyc;
        cnt64 = int'(b64.cnt);
      end
      step;
    end
    chk("w64_c10_pulses", c10n, 64);
    chk("w64_done_cyc", d64, 133);
    chk("w64_cnt_end", cnt64, 64);
    chk("w64_idle_after", b64.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
